// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared predictor counter encodings and prediction mode values
package cpu_pipe_pkg;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} cnt_e;
  localparam int PM_STATIC  = 0;
  localparam int PM_BIMODAL = 1;
endpackage

// File: rtl/bp_satcnt.sv
// bp_satcnt: 2-bit saturating counter next-state
module bp_satcnt
  import cpu_pipe_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  always_comb
    cnt_o = taken_i ? ((cnt_i == ST) ? ST : cnt_i + 2'd1)
                    : ((cnt_i == SNT) ? SNT : cnt_i - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped bimodal predictor with BTB, mispredict detect and perf counters
module branch_predictor
  import cpu_pipe_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          ENTRIES   = 16,
  parameter int          PRED_MODE = PM_BIMODAL,
  parameter logic [31:0] PERF_INIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            p_hit,
  output logic            p_taken,
  output logic [XLEN-1:0] p_target,
  input  logic            u_valid,
  input  logic [XLEN-1:0] u_pc,
  input  logic [XLEN-1:0] u_target,
  input  logic            u_cond,
  input  logic            u_jal,
  input  logic            u_taken,
  input  logic            u_pred_taken,
  input  logic [XLEN-1:0] u_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_ctl,
  output logic [31:0]     perf_miss
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic BIMODAL = (PRED_MODE == PM_BIMODAL);
  logic            valid_q [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q  [ENTRIES];
  logic [XLEN-1:0] tgt_q   [ENTRIES];
  logic [31:0]     perf_ctl_q, perf_miss_q;
  logic [IDX_W-1:0] f_idx, u_idx;
  logic            u_hit, wr;
  logic [1:0]      sat_next, cnt_d;
  bp_satcnt u_sat (.cnt_i(cnt_q[u_idx]), .taken_i(u_taken), .cnt_o(sat_next));
  always_comb begin
    f_idx       = f_pc[IDX_W+1:2];
    u_idx       = u_pc[IDX_W+1:2];
    p_hit       = BIMODAL && !rst && valid_q[f_idx] && (tag_q[f_idx] == f_pc[XLEN-1:IDX_W+2]);
    p_taken     = p_hit && cnt_q[f_idx][1];
    p_target    = p_taken ? tgt_q[f_idx] : f_pc + XLEN'(4);
    u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_pc[XLEN-1:IDX_W+2]);
    // misses only allocate on taken; JALR never touches the table
    wr          = BIMODAL && u_valid && (u_cond || u_jal) && (u_hit || u_taken);
    cnt_d       = u_jal ? ST : u_hit ? sat_next : WT;
    mispredict  = u_valid && ((u_pred_taken != u_taken) || (u_taken && (u_pred_target != u_target)));
    redirect_pc = u_taken ? u_target : u_pc + XLEN'(4);
    perf_ctl    = perf_ctl_q;
    perf_miss   = perf_miss_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= SNT;
      end
      perf_ctl_q  <= PERF_INIT;
      perf_miss_q <= PERF_INIT;
    end else begin
      if (wr) begin
        valid_q[u_idx] <= 1'b1;
        cnt_q[u_idx]   <= cnt_d;
      end
      if (u_valid && perf_ctl_q != '1) perf_ctl_q <= perf_ctl_q + 32'd1;
      if (mispredict && perf_miss_q != '1) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr) begin
      tag_q[u_idx] <= u_pc[XLEN-1:IDX_W+2];
      if (u_taken) tgt_q[u_idx] <= u_target;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven directed checks of branch_predictor plus reset and saturation sequences
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc, u_pc, u_target, u_pred_target;
  logic        u_valid, u_cond, u_jal, u_taken, u_pred_taken;
  logic        hit_b, tk_b, mis_b, hit_s, tk_s, mis_s, hit_h, tk_h, mis_h;
  logic [31:0] tgt_b, red_b, ctl_b, miss_b, tgt_s, red_s, ctl_s, miss_s, tgt_h, red_h, ctl_h, miss_h;
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  branch_predictor #(.PRED_MODE(1)) u_dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .p_hit(hit_b), .p_taken(tk_b), .p_target(tgt_b),
    .u_valid(u_valid), .u_pc(u_pc), .u_target(u_target), .u_cond(u_cond), .u_jal(u_jal),
    .u_taken(u_taken), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .mispredict(mis_b), .redirect_pc(red_b), .perf_ctl(ctl_b), .perf_miss(miss_b));
  branch_predictor #(.PRED_MODE(0)) u_static (
    .clk(clk), .rst(rst), .f_pc(f_pc), .p_hit(hit_s), .p_taken(tk_s), .p_target(tgt_s),
    .u_valid(u_valid), .u_pc(u_pc), .u_target(u_target), .u_cond(u_cond), .u_jal(u_jal),
    .u_taken(u_taken), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .mispredict(mis_s), .redirect_pc(red_s), .perf_ctl(ctl_s), .perf_miss(miss_s));
  branch_predictor #(.PRED_MODE(1), .PERF_INIT(32'hFFFF_FFFD)) u_hook (
    .clk(clk), .rst(rst), .f_pc(f_pc), .p_hit(hit_h), .p_taken(tk_h), .p_target(tgt_h),
    .u_valid(u_valid), .u_pc(u_pc), .u_target(u_target), .u_cond(u_cond), .u_jal(u_jal),
    .u_taken(u_taken), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
    .mispredict(mis_h), .redirect_pc(red_h), .perf_ctl(ctl_h), .perf_miss(miss_h));
  typedef struct {
    logic uv, uc, uj, ut, upt;
    logic [31:0] upc, utgt, uptgt, fpc;
    logic eh, et;
    logic [31:0] etgt;
    logic emis;
    logic [31:0] ered, ectl, emiss;
  } vec_t;
  vec_t vecs [16];
  function automatic vec_t mk(logic uv, uc, uj, ut, upt, logic [31:0] upc, utgt, uptgt, fpc,
                              logic eh, et, logic [31:0] etgt, logic emis, logic [31:0] ered, ectl, emiss);
    vec_t v;
    v.uv = uv; v.uc = uc; v.uj = uj; v.ut = ut; v.upt = upt;
    v.upc = upc; v.utgt = utgt; v.uptgt = uptgt; v.fpc = fpc;
    v.eh = eh; v.et = et; v.etgt = etgt; v.emis = emis; v.ered = ered; v.ectl = ectl; v.emiss = emiss;
    return v;
  endfunction
  function automatic logic [31:0] sat(logic [31:0] base, logic [31:0] inc);
    logic [32:0] s;
    s = {1'b0, base} + {1'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    u_valid = 0; u_cond = 0; u_jal = 0; u_taken = 0; u_pred_taken = 0;
    u_pc = 0; u_target = 0; u_pred_target = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic jalr_miss(logic [31:0] tgt);
    idle();
    u_valid = 1; u_taken = 1; u_pc = 32'h500; u_target = tgt;
  endtask
  initial begin
    //            uv uc uj ut upt upc            utgt           uptgt          fpc            eh et etgt           emis ered           ctl miss
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h100,       0, 0, 32'h104,       0, 32'h0,   0, 0);
    vecs[1]  = mk(1, 1, 0, 1, 0, 32'h100,      32'h80,       32'h0,        32'h100,       0, 0, 32'h104,       1, 32'h80,  0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 1, 32'h100,      32'h80,       32'h80,       32'h100,       1, 1, 32'h80,        1, 32'h104, 1, 1);
    vecs[3]  = mk(1, 1, 0, 0, 0, 32'h100,      32'h80,       32'h0,        32'h100,       1, 0, 32'h104,       0, 32'h104, 2, 2);
    vecs[4]  = mk(1, 1, 0, 1, 0, 32'h100,      32'h80,       32'h0,        32'h100,       1, 0, 32'h104,       1, 32'h80,  3, 2);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h100,       1, 0, 32'h104,       0, 32'h0,   4, 3);
    vecs[6]  = mk(1, 0, 1, 1, 1, 32'h140,      32'h200,      32'h200,      32'h140,       0, 0, 32'h144,       0, 32'h200, 4, 3);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h100,       0, 0, 32'h104,       0, 32'h0,   5, 3);
    vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h140,       1, 1, 32'h200,       0, 32'h0,   5, 3);
    vecs[9]  = mk(1, 0, 0, 1, 1, 32'h140,      32'h300,      32'h200,      32'h140,       1, 1, 32'h200,       1, 32'h300, 5, 3);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h140,       1, 1, 32'h200,       0, 32'h0,   6, 4);
    vecs[11] = mk(1, 1, 0, 0, 0, 32'h184,      32'h0,        32'h0,        32'h184,       0, 0, 32'h188,       0, 32'h188, 6, 4);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h184,       0, 0, 32'h188,       0, 32'h0,   7, 4);
    vecs[13] = mk(1, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0,       32'h0,        32'hFFFF_FFFF, 0, 0, 32'h3,         1, 32'h3,   7, 4);
    vecs[14] = mk(1, 0, 1, 1, 1, 32'h140,      32'h400,      32'h200,      32'h140,       1, 1, 32'h200,       1, 32'h400, 8, 5);
    vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h140,       1, 1, 32'h400,       0, 32'h0,   9, 6);
    idle();
    f_pc = 32'h100;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", 32'(hit_b), 0);
    chk("rst_target", tgt_b, 32'h104);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      u_valid = vecs[i].uv; u_cond = vecs[i].uc; u_jal = vecs[i].uj; u_taken = vecs[i].ut;
      u_pred_taken = vecs[i].upt; u_pc = vecs[i].upc; u_target = vecs[i].utgt;
      u_pred_target = vecs[i].uptgt; f_pc = vecs[i].fpc;
      #2;
      chk($sformatf("v%0d p_hit", i), 32'(hit_b), 32'(vecs[i].eh));
      chk($sformatf("v%0d p_taken", i), 32'(tk_b), 32'(vecs[i].et));
      chk($sformatf("v%0d p_target", i), tgt_b, vecs[i].etgt);
      chk($sformatf("v%0d mispredict", i), 32'(mis_b), 32'(vecs[i].emis));
      if (vecs[i].emis) chk($sformatf("v%0d redirect_pc", i), red_b, vecs[i].ered);
      chk($sformatf("v%0d perf_ctl", i), ctl_b, vecs[i].ectl);
      chk($sformatf("v%0d perf_miss", i), miss_b, vecs[i].emiss);
      chk($sformatf("v%0d static p_taken", i), {31'b0, hit_s | tk_s}, 0);
      chk($sformatf("v%0d static p_target", i), tgt_s, vecs[i].fpc + 32'd4);
      chk($sformatf("v%0d static mispredict", i), 32'(mis_s), 32'(vecs[i].emis));
      chk($sformatf("v%0d static perf_miss", i), miss_s, vecs[i].emiss);
      chk($sformatf("v%0d hook perf_ctl", i), ctl_h, sat(32'hFFFF_FFFD, vecs[i].ectl));
      tick();
    end
    // reset coinciding with a taken update: reset wins and outputs are quiet while rst is high
    idle();
    u_valid = 1; u_cond = 1; u_taken = 1; u_pc = 32'h100; u_target = 32'h80;
    f_pc = 32'h140;
    rst = 1;
    #2;
    chk("during_rst p_hit", 32'(hit_b), 0);
    chk("during_rst p_target", tgt_b, 32'h144);
    tick();
    rst = 0;
    idle();
    f_pc = 32'h100;
    #2;
    chk("post_rst perf_ctl", ctl_b, 0);
    chk("post_rst perf_miss", miss_b, 0);
    chk("post_rst hit 0x100", 32'(hit_b), 0);
    f_pc = 32'h140;
    #2;
    chk("post_rst hit 0x140", 32'(hit_b), 0);
    chk("post_rst hook perf_miss", miss_h, 32'hFFFF_FFFD);
    // drive perf_miss into saturation on the preloaded instance
    for (int k = 0; k < 4; k++) begin
      jalr_miss(32'h600 + 32'(k));
      #2;
      chk($sformatf("sat%0d mispredict", k), 32'(mis_h), 1);
      tick();
      idle();
      #1;
      chk($sformatf("sat%0d hook perf_miss", k), miss_h, sat(32'hFFFF_FFFD, 32'(k + 1)));
      chk($sformatf("sat%0d hook perf_ctl", k), ctl_h, sat(32'hFFFF_FFFD, 32'(k + 1)));
      chk($sformatf("sat%0d main perf_miss", k), miss_b, 32'(k + 1));
    end
    chk("jalr left table empty", 32'(hit_b), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
